// File: rtl/eth_mac_pkg.sv
// Shared definitions for the MAC transmit path: arbitration modes, scheduler
// state encoding and per-queue slice addressing.
package eth_mac_pkg;

  localparam int ARB_MODE_RR = 0;
  localparam int ARB_MODE_SP = 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } sched_state_e;

  // Bit offset of queue q inside a flattened per-queue bus of w-bit slices.
  function automatic int slice_base(input int q, input int w);
    return q * w;
  endfunction

endpackage

// File: rtl/eth_tx_queue_arb.sv
// Combinational queue picker: round-robin after the last grant, or lowest
// eligible index when strict priority is selected.
module eth_tx_queue_arb
  import eth_mac_pkg::*;
#(
  parameter int QUEUE_COUNT = 4,
  parameter int QW          = $clog2(QUEUE_COUNT)
) (
  input  logic [QUEUE_COUNT-1:0] eligible,
  input  logic [QW-1:0]          last_ptr,
  input  logic                   mode,
  output logic [QW-1:0]          grant,
  output logic                   grant_valid
);

  logic [QW-1:0] cand;

  // Candidates are visited from lowest to highest priority so the last hit wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int i = QUEUE_COUNT; i >= 1; i--) begin
      if (mode == 1'(ARB_MODE_SP)) cand = QW'(i - 1);
      else                         cand = QW'((int'(last_ptr) + i) % QUEUE_COUNT);
      if (eligible[cand]) begin
        grant       = cand;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_mac_tx_queue_sched.sv
// Frame-atomic multi-queue TX scheduler feeding the MAC through a registered
// main + skid output stage; queues are chosen only between frames.
module eth_mac_tx_queue_sched
  import eth_mac_pkg::*;
#(
  parameter int DATA_WIDTH  = 128,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int USER_WIDTH  = 1,
  parameter int QUEUE_COUNT = 4,
  parameter int ARB_MODE    = 0,
  parameter int QW          = $clog2(QUEUE_COUNT)
) (
  input  logic                              tx_clk,
  input  logic                              tx_rst,
  input  logic [QUEUE_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [QUEUE_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [QUEUE_COUNT-1:0]            s_axis_tvalid,
  output logic [QUEUE_COUNT-1:0]            s_axis_tready,
  input  logic [QUEUE_COUNT-1:0]            s_axis_tlast,
  input  logic [QUEUE_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]             m_axis_tkeep,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [USER_WIDTH-1:0]             m_axis_tuser,
  input  logic                              cfg_enable,
  input  logic [QUEUE_COUNT-1:0]            cfg_pause_mask,
  output logic [QW-1:0]                     stat_queue,
  output logic                              stat_frame_start,
  output logic                              stat_frame_done
);

  sched_state_e state;
  logic [QW-1:0] grant_q;
  logic [QW-1:0] rr_ptr;

  logic [QUEUE_COUNT-1:0] eligible;
  logic [QW-1:0]          arb_grant;
  logic                   arb_valid;

  logic [DATA_WIDTH-1:0] skid_data;
  logic [KEEP_WIDTH-1:0] skid_keep;
  logic                  skid_last;
  logic [USER_WIDTH-1:0] skid_user;
  logic                  skid_vld;

  logic [DATA_WIDTH-1:0] in_data;
  logic [KEEP_WIDTH-1:0] in_keep;
  logic [USER_WIDTH-1:0] in_user;
  logic                  in_last;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_accept;

  assign eligible = cfg_enable ? (s_axis_tvalid & ~cfg_pause_mask) : '0;

  eth_tx_queue_arb #(
    .QUEUE_COUNT (QUEUE_COUNT),
    .QW          (QW)
  ) u_arb (
    .eligible    (eligible),
    .last_ptr    (rr_ptr),
    .mode        (ARB_MODE == ARB_MODE_SP),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  assign in_data   = s_axis_tdata[slice_base(int'(grant_q), DATA_WIDTH) +: DATA_WIDTH];
  assign in_keep   = s_axis_tkeep[slice_base(int'(grant_q), KEEP_WIDTH) +: KEEP_WIDTH];
  assign in_user   = s_axis_tuser[slice_base(int'(grant_q), USER_WIDTH) +: USER_WIDTH];
  assign in_last   = s_axis_tlast[grant_q];
  assign in_valid  = s_axis_tvalid[grant_q];
  assign in_ready  = (state == ST_ACTIVE) && !skid_vld;
  assign in_accept = in_ready && in_valid;

  always_comb begin
    s_axis_tready = '0;
    if (in_ready) s_axis_tready[grant_q] = 1'b1;
  end

  assign stat_queue = grant_q;

  // Grant / frame FSM: arbitration happens only in IDLE, so pause and enable
  // changes never cut a frame short.
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state            <= ST_IDLE;
      grant_q          <= '0;
      rr_ptr           <= QW'(QUEUE_COUNT - 1);
      stat_frame_start <= 1'b0;
      stat_frame_done  <= 1'b0;
    end else begin
      stat_frame_start <= 1'b0;
      stat_frame_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_q          <= arb_grant;
            rr_ptr           <= arb_grant;
            state            <= ST_ACTIVE;
            stat_frame_start <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (in_accept && in_last) begin
            state           <= ST_IDLE;
            stat_frame_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output stage: main register drives the MAC, skid catches the one beat
  // accepted while the MAC stalls.
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      m_axis_tvalid <= 1'b0;
      skid_data     <= '0;
      skid_keep     <= '0;
      skid_last     <= 1'b0;
      skid_user     <= '0;
      skid_vld      <= 1'b0;
    end else if (!m_axis_tvalid || m_axis_tready) begin
      if (skid_vld) begin
        m_axis_tdata  <= skid_data;
        m_axis_tkeep  <= skid_keep;
        m_axis_tlast  <= skid_last;
        m_axis_tuser  <= skid_user;
        m_axis_tvalid <= 1'b1;
        skid_vld      <= 1'b0;
      end else begin
        m_axis_tvalid <= in_accept;
        if (in_accept) begin
          m_axis_tdata <= in_data;
          m_axis_tkeep <= in_keep;
          m_axis_tlast <= in_last;
          m_axis_tuser <= in_user;
        end
      end
    end else if (in_accept) begin
      skid_data <= in_data;
      skid_keep <= in_keep;
      skid_last <= in_last;
      skid_user <= in_user;
      skid_vld  <= 1'b1;
    end
  end

endmodule
